inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 139 +++++++++++++
 tb/tb_inst_mem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams 32-bit instruction words into a byte-wide
// instruction memory. Each accepted word takes four big-endian byte strobes,
// and then the write base advances by four.
// Optional build macro INST_LOADER_WRAP_EN: when it is defined, loading wraps
// from the top of memory back to address 0. When it is undefined, the loader
// parks in FULL after it writes the last word of memory.
module inst_mem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [6:0]        word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_FULL
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_word;
  logic [1:0]        r_beat;
  logic [6:0]        r_wcnt;
  logic              r_err;

  logic w_aligned;
  logic w_last_beat;
  logic w_top;
  logic w_accept;
  logic w_restart;

  assign w_aligned   = (start_addr[1:0] == 2'b00);
  assign w_last_beat = (r_beat == 2'd3);
  // The word at the highest aligned base makes base+4 wrap to zero.
  assign w_top       = &r_base[ADDR_W-1:2];
  assign w_accept    = (r_state == S_ACCEPT) && !stop && in_valid;
  assign w_restart   = start && w_aligned &&
                       ((r_state == S_IDLE) || ((r_state == S_FULL) && !stop));

  // State register. Reset returns to IDLE at once, without waiting for a clock.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode. In ACCEPT and FULL, stop takes priority.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start && w_aligned) w_next_state = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (stop)          w_next_state = S_IDLE;
        else if (in_valid) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (w_last_beat) begin
`ifdef INST_LOADER_WRAP_EN
          w_next_state = S_ACCEPT;
`else
          w_next_state = w_top ? S_FULL : S_ACCEPT;
`endif
        end
      end
      S_FULL: begin
        if (stop)                    w_next_state = S_IDLE;
        else if (start && w_aligned) w_next_state = S_ACCEPT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Session datapath: base, captured word, beat index, word counter, error pulse.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_base <= '0;
      r_word <= '0;
      r_beat <= '0;
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && start && !w_aligned;
      if (w_restart) begin
        r_base <= start_addr;
        r_wcnt <= '0;
      end
      if (w_accept) begin
        r_word <= in_data;
        r_beat <= '0;
      end
      if (r_state == S_WRITE) begin
        r_beat <= r_beat + 2'd1;
        if (w_last_beat) begin
          r_base <= r_base + ADDR_W'(4);
          r_wcnt <= r_wcnt + 7'd1;
        end
      end
    end
  end

  // Output decode. Address and data are held at zero whenever there is no strobe.
  always_comb begin
    in_ready   = (r_state == S_ACCEPT);
    mem_we     = (r_state == S_WRITE);
    busy       = (r_state != S_IDLE);
    full       = (r_state == S_FULL);
    err        = r_err;
    word_count = r_wcnt;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (r_state == S_WRITE) begin
      mem_addr = r_base + ADDR_W'(r_beat);
      unique case (r_beat)
        2'd0:    mem_wdata = r_word[31:24];
        2'd1:    mem_wdata = r_word[23:16];
        2'd2:    mem_wdata = r_word[15:8];
        default: mem_wdata = r_word[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Testbench for inst_mem_loader. It drives directed vectors and checks the
// outputs on every cycle against a transaction-level model kept in the bench.
// The expected top-of-memory behaviour follows INST_LOADER_WRAP_EN.
module tb_inst_mem_loader;

  logic        CLK;
  logic        CLR;
  logic        start;
  logic [7:0]  start_addr;
  logic        stop;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        full;
  logic        err;
  logic [6:0]  word_count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          cmp_en = 1'b0;

  inst_mem_loader #(.ADDR_W(8)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .start_addr(start_addr), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .full(full), .err(err), .word_count(word_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Shadow of the instruction memory, built from the DUT's write strobes.
  logic [7:0] shadow [0:255];
  initial for (int i = 0; i < 256; i++) shadow[i] = 8'hAA;
  always @(posedge CLK) if (mem_we === 1'b1) shadow[mem_addr] <= mem_wdata;

  // Model: session flags plus a queue of byte writes still owed.
  typedef struct { int unsigned a; int unsigned d; } wr_t;
  wr_t         q[$];
  bit          m_active = 0, m_full = 0, m_err = 0;
  int unsigned m_base = 0, m_wc = 0;

  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q.delete(); m_active = 0; m_full = 0; m_err = 0; m_base = 0; m_wc = 0;
    end else begin
      m_err = 0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_wc++;
`ifndef INST_LOADER_WRAP_EN
          if (m_base == 252) m_full = 1;
`endif
          m_base = (m_base + 4) % 256;
        end
      end else if (!m_active) begin
        if (start && start_addr % 4 != 0) m_err = 1;
        if (start && start_addr % 4 == 0) begin
          m_active = 1; m_base = start_addr; m_wc = 0; m_full = 0;
        end
      end else if (m_full) begin
        if (stop) begin m_active = 0; m_full = 0; end
        else if (start && start_addr % 4 == 0) begin
          m_base = start_addr; m_wc = 0; m_full = 0;
        end
      end else begin
        if (stop) m_active = 0;
        else if (in_valid)
          for (int b = 0; b < 4; b++)
            q.push_back('{a: (m_base + b) % 256, d: (in_data >> (24 - 8 * b)) & 32'hFF});
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("mem_we",     mem_we,     (q.size() > 0));
      check("mem_addr",   mem_addr,   (q.size() > 0) ? q[0].a : 0);
      check("mem_wdata",  mem_wdata,  (q.size() > 0) ? q[0].d : 0);
      check("in_ready",   in_ready,   m_active && !m_full && q.size() == 0);
      check("busy",       busy,       m_active);
      check("full",       full,       m_full);
      check("err",        err,        m_err);
      check("word_count", word_count, m_wc % 128);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int unsigned n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("rdy_wait", in_ready, 1);
    in_valid = 1; in_data = w; tick(); in_valid = 0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e038 [0:3];
    logic [7:0] e040 [0:7];
    logic [7:0] e024 [0:3];
    e038 = '{8'hE0, 8'h82, 8'h50, 8'h05};
    e040 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    e024 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    CLR = 1; start = 0; start_addr = 0; stop = 0; in_valid = 0; in_data = 0;
    #2 CLR = 0;
    #1 cmp_en = 1;
    repeat (2) tick();
    check("rst_ready", in_ready, 0);
    check("rst_we",    mem_we,   0);
    check("rst_busy",  busy,     0);
    check("rst_wc",    word_count, 0);

    // First start is honoured on the first edge after reset release.
    CLR = 1; start = 1; start_addr = 8'h00;
    tick(); start = 0;
    check("start_busy",  busy,     1);
    check("start_ready", in_ready, 1);
    in_valid = 1; in_data = 32'hE0825005;
    tick(); in_valid = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      check("w038_we",   mem_we,    1);
      check("w038_addr", mem_addr,  k);
      check("w038_data", mem_wdata, e038[k]);
      tick();
    end
    check("w038_ready", in_ready,   1);
    check("w038_wc",    word_count, 1);
    for (int unsigned k = 0; k < 4; k++) check("w038_mem", shadow[k], e038[k]);

    // stop beats a simultaneous in_valid.
    stop = 1; in_valid = 1; in_data = 32'hDEADBEEF;
    tick(); stop = 0; in_valid = 0;
    check("stop_busy", busy, 0);
    check("stop_wc",   word_count, 1);
    tick();
    check("stop_mem", shadow[4], 8'hAA);

    // A misaligned start is rejected with a one-cycle error pulse.
    start = 1; start_addr = 8'h06;
    tick(); start = 0;
    check("mis_err",  err,  1);
    check("mis_busy", busy, 0);
    tick();
    check("mis_err_clr", err, 0);

    // Loading the last two words of memory.
    start = 1; start_addr = 8'hF8;
    tick(); start = 0;
    send_word(32'h11223344);
    send_word(32'h55667788);
    for (int unsigned k = 0; k < 8; k++) check("top_mem", shadow[248 + k], e040[k]);
`ifdef INST_LOADER_WRAP_EN
    check("wrap_ready", in_ready, 1);
    send_word(32'h00000000);
    check("wrap_full", full, 0);
    check("wrap_wc",   word_count, 3);
    for (int unsigned k = 0; k < 4; k++) check("wrap_mem", shadow[k], 0);
`else
    check("top_full",  full,     1);
    check("top_ready", in_ready, 0);
    in_valid = 1; in_data = 32'h00000000;
    repeat (3) tick();
    in_valid = 0;
    check("top_ign_mem", shadow[0], 8'hE0);
    check("top_wc",      word_count, 2);
`endif
    stop = 1; tick(); stop = 0;
    check("top_stop_busy", busy, 0);
    check("top_stop_full", full, 0);

    // stop and start during WRITE are ignored; the word completes.
    start = 1; start_addr = 8'h10;
    tick(); start = 0;
    in_valid = 1; in_data = 32'hA1B2C3D4;
    tick(); in_valid = 0;
    stop = 1; start = 1; start_addr = 8'h40;
    repeat (3) tick();
    stop = 0; start = 0;
    tick();
    check("wr_ign_busy",  busy,     1);
    check("wr_ign_ready", in_ready, 1);
    check("wr_ign_wc",    word_count, 1);
    for (int unsigned k = 0; k < 4; k++) check("wr_ign_mem", shadow[16 + k], e024[k]);

    // Reset after beat 1 aborts the word.
    in_valid = 1; in_data = 32'hDB000001;
    tick(); in_valid = 0;
    tick();
    @(posedge CLK);
    CLR = 0;
    #1;
    check("rst_mid_we",    mem_we,    0);
    check("rst_mid_addr",  mem_addr,  0);
    check("rst_mid_data",  mem_wdata, 0);
    check("rst_mid_ready", in_ready,  0);
    check("rst_mid_busy",  busy,      0);
    check("rst_mid_wc",    word_count, 0);
    repeat (3) tick();
    check("rst_mid_b0", shadow[20], 8'hDB);
    check("rst_mid_b1", shadow[21], 8'h00);
    check("rst_mid_b2", shadow[22], 8'hAA);
    check("rst_mid_b3", shadow[23], 8'hAA);
    CLR = 1;
    repeat (3) tick();
    check("post_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
